// File: rtl/icache_pkg.sv
// Shared widths, FSM encoding and address field helpers for the direct-mapped
// instruction cache.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int NUM_SETS   = 64;
  localparam int LINE_WORDS = 4;

  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;
  // One extra bit so a counter can reach LINE_WORDS without wrapping.
  localparam int CNT_W    = OFFSET_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fsm_state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_FILL   = FILL;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W+2 +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[2 +: OFFSET_W];
  endfunction

endpackage

// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and memory-side signals of the instruction cache; the cache is
// the slave, the PC stage plus memory model together form the master.
interface icache_fetch_responder_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] fetch_addr;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_valid;
  logic                  stall;
  logic                  invalidate;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  modport slave (
    input  fetch_addr, invalidate, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output instr, instr_valid, stall, mem_req_valid, mem_req_addr
  );

  modport master (
    output fetch_addr, invalidate, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  instr, instr_valid, stall, mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Line refill sequencer: IDLE/FILL/COMMIT FSM, request/response counters and
// the deferred fence.i invalidate.
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   fetch_addr,
  input  logic                lookup_miss,
  input  logic                invalidate,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                idle,
  output logic                fill_we,
  output logic [OFFSET_W-1:0] fill_word,
  output logic                commit,
  output logic [ADDR_W-1:0]   line_base,
  output logic                clear_all
);

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  req_cnt_r;
  logic [CNT_W-1:0]  rsp_cnt_r;
  logic [ADDR_W-1:0] base_r;
  logic              inv_pend_r;
  logic              req_fire_s;

  assign idle          = (state_r == ST_IDLE);
  assign commit        = (state_r == ST_COMMIT);
  assign mem_req_valid = (state_r == ST_FILL) && (req_cnt_r < CNT_W'(LINE_WORDS));
  assign mem_req_addr  = base_r + {{(ADDR_W-CNT_W-2){1'b0}}, req_cnt_r, 2'b00};
  assign req_fire_s    = mem_req_valid && mem_req_ready;
  assign fill_we       = (state_r == ST_FILL) && mem_rsp_valid && !rst;
  assign fill_word     = rsp_cnt_r[OFFSET_W-1:0];
  assign line_base     = base_r;
  // An invalidate seen during a refill is applied on the first IDLE cycle.
  assign clear_all     = idle && (invalidate || inv_pend_r);

  // FSM, counters, latched line base and pending invalidate
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      req_cnt_r  <= {CNT_W{1'b0}};
      rsp_cnt_r  <= {CNT_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      inv_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          inv_pend_r <= 1'b0;
          if (lookup_miss) begin
            base_r  <= {get_tag(fetch_addr), get_index(fetch_addr), {(OFFSET_W+2){1'b0}}};
            state_r <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (req_fire_s) begin
            req_cnt_r <= req_cnt_r + CNT_W'(1);
          end
          if (mem_rsp_valid) begin
            rsp_cnt_r <= rsp_cnt_r + CNT_W'(1);
            if (rsp_cnt_r == CNT_W'(LINE_WORDS - 1)) begin
              state_r <= ST_COMMIT;
            end
          end
          if (invalidate) begin
            inv_pend_r <= 1'b1;
          end
        end
        ST_COMMIT: begin
          req_cnt_r <= {CNT_W{1'b0}};
          rsp_cnt_r <= {CNT_W{1'b0}};
          state_r   <= ST_IDLE;
          if (invalidate) begin
            inv_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache: zero-latency lookup of the fetch address,
// stall plus 4-word line refill from memory on a miss.
module icache_fetch_responder
  import icache_pkg::*;
#(
  parameter int DATA_WIDTH     = ADDR_W,
  parameter int SETS           = NUM_SETS,
  parameter int WORDS_PER_LINE = LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  icache_fetch_responder_if.slave bus
);

  logic [INDEX_W-1:0]    idx_s;
  logic [OFFSET_W-1:0]   off_s;
  logic [TAG_W-1:0]      tag_s;
  logic                  hit_s;
  logic                  idle_s;
  logic                  fill_we_s;
  logic [OFFSET_W-1:0]   fill_word_s;
  logic                  commit_s;
  logic                  clear_all_s;
  logic [DATA_WIDTH-1:0] line_base_s;
  logic [INDEX_W-1:0]    fill_idx_s;
  logic                  unused_s;

  logic [DATA_WIDTH-1:0] data_r [SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]      tag_r  [SETS];
  logic [SETS-1:0]       valid_r;

  assign idx_s      = get_index(bus.fetch_addr);
  assign off_s      = get_offset(bus.fetch_addr);
  assign tag_s      = get_tag(bus.fetch_addr);
  assign fill_idx_s = get_index(line_base_s);
  assign unused_s   = ^{bus.fetch_addr[1:0], line_base_s[OFFSET_W+1:0]};

  assign hit_s           = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign bus.instr       = data_r[idx_s][off_s];
  assign bus.instr_valid = idle_s && hit_s;
  assign bus.stall       = !(idle_s && hit_s);

  icache_refill_ctrl u_refill (
    .clk           (clk),
    .rst           (rst),
    .fetch_addr    (bus.fetch_addr),
    .lookup_miss   (!hit_s),
    .invalidate    (bus.invalidate),
    .mem_req_ready (bus.mem_req_ready),
    .mem_rsp_valid (bus.mem_rsp_valid),
    .mem_req_valid (bus.mem_req_valid),
    .mem_req_addr  (bus.mem_req_addr),
    .idle          (idle_s),
    .fill_we       (fill_we_s),
    .fill_word     (fill_word_s),
    .commit        (commit_s),
    .line_base     (line_base_s),
    .clear_all     (clear_all_s)
  );

  // Per-set valid flags; invalidate and commit never coincide (IDLE vs COMMIT)
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {SETS{1'b0}};
    end else if (clear_all_s) begin
      valid_r <= {SETS{1'b0}};
    end else if (commit_s) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Data and tag storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      data_r[fill_idx_s][fill_word_s] <= bus.mem_rsp_data;
    end
    if (commit_s) begin
      tag_r[fill_idx_s] <= get_tag(line_base_s);
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed plus randomized bench for icache_fetch_responder with a queue-based
// memory model and an abstract tag/valid reference of cache contents.
module tb_icache_fetch_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] fetch_addr_d = 32'h0;
  logic        inv_d        = 1'b0;
  logic        ready_d      = 1'b1;
  logic        rsp_valid_d  = 1'b0;
  logic [31:0] rsp_data_d   = 32'h0;

  icache_fetch_responder_if #(.DATA_WIDTH(32)) bus ();

  assign bus.fetch_addr    = fetch_addr_d;
  assign bus.invalidate    = inv_d;
  assign bus.mem_req_ready = ready_d;
  assign bus.mem_rsp_valid = rsp_valid_d;
  assign bus.mem_rsp_data  = rsp_data_d;

  icache_fetch_responder #(.DATA_WIDTH(32), .SETS(64), .WORDS_PER_LINE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lat      = 2;
  bit rand_ready = 1'b0;
  int bp_left  = 0;
  int bp_start = 0;
  int rsp_total = 0;
  logic [31:0] seed = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend_q[$];
  logic [31:0] req_log[$];

  bit          m_valid[64];
  int unsigned m_tag[64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned set;
    set = (a >> 4) % 64;
    return m_valid[set] && (m_tag[set] == (a >> 10));
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_valid[(a >> 4) % 64] = 1'b1;
    m_tag[(a >> 4) % 64]   = a >> 10;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: accepts word requests, returns data in order after lat cycles
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      rsp_valid_d = 1'b0;
      ready_d     = 1'b1;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
        rsp_total++;
      end else begin
        rsp_valid_d = 1'b0;
      end
      if (bp_left > 0 && bus.mem_req_valid && req_log.size() == bp_start + 1) begin
        chk("bp_addr_stable", bus.mem_req_addr, 32'hBFC00004);
        chk("bp_stall", {31'h0, bus.stall}, 32'h1);
        ready_d = 1'b0;
        bp_left--;
      end else if (rand_ready) begin
        ready_d = ($urandom_range(0, 3) != 0);
      end else begin
        ready_d = 1'b1;
      end
      if (bus.mem_req_valid && ready_d) begin
        pend_q.push_back('{bus.mem_req_addr, cyc + lat});
        req_log.push_back(bus.mem_req_addr);
      end
    end
  end

  task automatic wait_hit(input logic [31:0] a, input string name);
    int n = 0;
    bit dropped = 1'b0;
    while (bus.instr_valid !== 1'b1 && n < 300) begin
      if (bus.stall !== 1'b1) dropped = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, {31'h0, (n < 300)}, 32'h1);
    chk({name, "_stall_held"}, {31'h0, dropped}, 32'h0);
    chk({name, "_instr"}, bus.instr, mem_word(a));
    chk({name, "_stall_off"}, {31'h0, bus.stall}, 32'h0);
    model_fill(a);
  endtask

  task automatic do_fetch(input logic [31:0] a, input string name);
    @(posedge clk); #1;
    fetch_addr_d = a;
    @(negedge clk);
    if (model_hit(a)) begin
      chk({name, "_hit_valid"}, {31'h0, bus.instr_valid}, 32'h1);
      chk({name, "_hit_instr"}, bus.instr, mem_word(a));
      chk({name, "_hit_noreq"}, {31'h0, bus.mem_req_valid}, 32'h0);
    end else begin
      chk({name, "_miss_stall"}, {31'h0, bus.stall}, 32'h1);
      chk({name, "_miss_valid"}, {31'h0, bus.instr_valid}, 32'h0);
      wait_hit(a, name);
    end
  endtask

  initial begin
    int unsigned tags[3];
    logic [31:0] a;
    int n;
    seed = $urandom;
    tags[0] = 32'h2FF000;
    tags[1] = 32'h000123;
    tags[2] = 32'h155555;
    model_clear();

    // Reset and cold miss on the boot vector
    rst = 1'b1;
    fetch_addr_d = 32'hBFC00000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    req_log.delete();
    @(negedge clk);
    chk("rst_stall", {31'h0, bus.stall}, 32'h1);
    chk("rst_instr_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    wait_hit(32'hBFC00000, "boot");
    chk("boot_req_cnt", req_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("boot_req_addr", req_log[i], 32'hBFC00000 + 32'(4 * i));

    // Same-line hits
    do_fetch(32'hBFC00004, "seq4");
    do_fetch(32'hBFC00008, "seq8");
    do_fetch(32'hBFC0000C, "seqC");

    // Conflict eviction
    do_fetch(32'hBFC00400, "conflict");
    chk("evict_predicted", {31'h0, model_hit(32'hBFC00000)}, 32'h0);
    do_fetch(32'hBFC00000, "evicted");

    // Back-pressure on the second request of a line
    do_fetch(32'hBFC00400, "bp_evict");
    bp_start = req_log.size();
    bp_left  = 3;
    do_fetch(32'hBFC00000, "bp");
    chk("bp_consumed", bp_left, 32'd0);

    // Invalidate during FILL: line lands, hits once, then is gone
    @(posedge clk); #1;
    fetch_addr_d = 32'h00001040;
    @(negedge clk);
    chk("invf_miss", {31'h0, bus.stall}, 32'h1);
    @(posedge clk); #1 inv_d = 1'b1;
    @(posedge clk); #1 inv_d = 1'b0;
    wait_hit(32'h00001040, "invf_fill");
    @(negedge clk);
    chk("invf_cleared", {31'h0, bus.stall}, 32'h1);
    model_clear();
    wait_hit(32'h00001040, "invf_refill");

    // Invalidate in IDLE: same-cycle lookup still hits, next cycle misses
    @(posedge clk); #1 inv_d = 1'b1;
    @(negedge clk);
    chk("invi_old_hit", {31'h0, bus.instr_valid}, 32'h1);
    @(posedge clk); #1 inv_d = 1'b0;
    @(negedge clk);
    chk("invi_cleared", {31'h0, bus.stall}, 32'h1);
    model_clear();
    wait_hit(32'h00001040, "invi_refill");

    // Reset after two responses of a fill
    n = rsp_total;
    @(posedge clk); #1;
    fetch_addr_d = 32'h00002080;
    begin
      int w = 0;
      while (rsp_total < n + 2 && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("rstf_two_rsp", {31'h0, (w < 100)}, 32'h1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstf_no_req", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("rstf_miss", {31'h0, bus.stall}, 32'h1);
    chk("rstf_no_valid", {31'h0, bus.instr_valid}, 32'h0);
    model_clear();
    wait_hit(32'h00002080, "rstf_refill");

    // Randomized fetch stream against the reference contents model
    rand_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      lat = $urandom_range(1, 4);
      a = (tags[$urandom_range(0, 2)] << 10) | ($urandom_range(0, 7) << 4)
          | ($urandom_range(0, 3) << 2);
      do_fetch(a, "rand");
      if (it % 10 == 9) begin
        @(posedge clk); #1 inv_d = 1'b1;
        @(negedge clk);
        chk("rand_inv_old", {31'h0, bus.instr_valid}, 32'h1);
        @(posedge clk); #1 inv_d = 1'b0;
        model_clear();
        do_fetch(a, "rand_inv");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
